// File: rtl/lpc_host.sv
// LPC bus initiator: issues one IO/memory read or write cycle per request,
// samples the peripheral's SYNC and read data, and reports a completion status.
module lpc_host #(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned WAIT_MAX     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  lpc_ad_in,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  output logic        lpc_frame,
  output logic [7:0]  out_data,
  output logic [1:0]  out_status,
  output logic        out_done
);

  localparam int unsigned NrW = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned WtW = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StCt, StAddr, StWdata, StTar1, StTar2,
    StSync, StRdata, StPtar, StAbort, StAbortEnd
  } state_e;

  state_e state_q, state_d;

  logic [3:0]     ct_q, ct_d;
  logic [31:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [NrW-1:0] nr_cnt_q, nr_cnt_d;
  logic [WtW-1:0] wait_cnt_q, wait_cnt_d;
  logic           sync_err_q, sync_err_d;
  logic           unsup_acc;

  logic           frame_q, frame_d;
  logic           oe_q, oe_d;
  logic [3:0]     ad_q, ad_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [1:0]     status_q, status_d;
  logic [7:0]     data_q, data_d;

  logic is_write;
  logic req_ok;

  assign is_write = ct_q[1];
  // Only IO and memory cycles are generated; bit 0 must be clear.
  assign req_ok   = (in_cyctype_dir[3] == 1'b0) && (in_cyctype_dir[0] == 1'b0);

  // State, datapath and registered-output flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ct_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      nr_cnt_q   <= '0;
      wait_cnt_q <= '0;
      sync_err_q <= 1'b0;
      frame_q    <= 1'b1;
      oe_q       <= 1'b0;
      ad_q       <= 4'hF;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ct_q       <= ct_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      nr_cnt_q   <= nr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      sync_err_q <= sync_err_d;
      frame_q    <= frame_d;
      oe_q       <= oe_d;
      ad_q       <= ad_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      status_q   <= status_d;
      data_q     <= data_d;
    end
  end

  // Next-state and datapath updates for the bus cycle sequencer.
  always_comb begin
    state_d    = state_q;
    ct_d       = ct_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    nr_cnt_d   = nr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    sync_err_d = sync_err_q;
    unsup_acc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && ready_q) begin
          ct_d    = in_cyctype_dir;
          addr_d  = in_addr;
          wdata_d = in_data;
          if (req_ok) begin
            state_d    = StStart;
            sync_err_d = 1'b0;
            rdata_d    = '0;
          end else begin
            unsup_acc = 1'b1;
          end
        end
      end
      StStart: state_d = StCt;
      StCt: begin
        state_d = StAddr;
        // Address goes out MS nibble first: 4 nibbles for IO, 8 for memory.
        cnt_d   = (ct_q[3:2] == 2'b00) ? 3'd3 : 3'd7;
      end
      StAddr: begin
        if (cnt_q == 3'd0) begin
          state_d = is_write ? StWdata : StTar1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWdata: begin
        if (cnt_q == 3'd1) begin
          state_d = StTar1;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StTar1: state_d = StTar2;
      StTar2: begin
        state_d    = StSync;
        nr_cnt_d   = '0;
        wait_cnt_d = '0;
      end
      StSync: begin
        wait_cnt_d = wait_cnt_q + WtW'(1);
        unique case (lpc_ad_in)
          4'b0000, 4'b1010: begin
            if (lpc_ad_in == 4'b1010) sync_err_d = 1'b1;
            state_d = is_write ? StPtar : StRdata;
            cnt_d   = 3'd0;
          end
          4'b0101, 4'b0110: nr_cnt_d = '0;
          default:          nr_cnt_d = nr_cnt_q + NrW'(1);
        endcase
        // A valid SYNC on the final allowed cycle still wins over the abort.
        if (state_d == StSync &&
            (nr_cnt_d == NrW'(SYNC_TIMEOUT) || wait_cnt_d == WtW'(WAIT_MAX))) begin
          state_d = StAbort;
          cnt_d   = 3'd0;
        end
      end
      StRdata: begin
        if (cnt_q[0]) begin
          rdata_d[7:4] = lpc_ad_in;
          state_d      = StPtar;
          cnt_d        = 3'd0;
        end else begin
          rdata_d[3:0] = lpc_ad_in;
          cnt_d        = 3'd1;
        end
      end
      StPtar: begin
        if (cnt_q[0]) state_d = StIdle;
        else          cnt_d   = 3'd1;
      end
      StAbort: begin
        if (cnt_q == 3'd3) state_d = StAbortEnd;
        else               cnt_d   = cnt_q + 3'd1;
      end
      StAbortEnd: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    frame_d  = !(state_d == StStart || state_d == StAbort);
    oe_d     = (state_d == StStart) || (state_d == StCt) || (state_d == StAddr) ||
               (state_d == StWdata) || (state_d == StTar1) || (state_d == StAbort);
    ad_d     = 4'hF;
    ready_d  = (state_d == StIdle);
    done_d   = 1'b0;
    status_d = status_q;
    data_d   = data_q;
    unique case (state_d)
      StStart: ad_d = 4'h0;
      StCt:    ad_d = ct_q;
      StAddr:  ad_d = addr_q[{cnt_d, 2'b00} +: 4];
      StWdata: ad_d = wdata_q[{cnt_d[0], 2'b00} +: 4];
      default: ad_d = 4'hF;
    endcase
    if (unsup_acc) begin
      done_d   = 1'b1;
      status_d = 2'b11;
      data_d   = '0;
    end else if (state_q == StPtar && cnt_q[0]) begin
      done_d   = 1'b1;
      status_d = sync_err_q ? 2'b01 : 2'b00;
      data_d   = is_write ? 8'h00 : rdata_q;
    end else if (state_q == StAbortEnd) begin
      done_d   = 1'b1;
      status_d = 2'b10;
      data_d   = '0;
    end
  end

  assign lpc_frame  = frame_q;
  assign lpc_ad_oe  = oe_q;
  assign lpc_ad_out = ad_q;
  assign in_ready   = ready_q;
  assign out_done   = done_q;
  assign out_status = status_q;
  assign out_data   = data_q;

endmodule
